// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor sequencer.
// Optional feature macro used by this design: SERIAL_ADDSUB_OVF_EN
package serial_addsub_pkg;

    // Sequencer states: waiting for a request, streaming bits, holding a result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Operation select encoding on Data_in_Sub
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the shared 1-bit arithmetic resource.
module full_adder (
    input  logic Data_in_A,
    input  logic Data_in_B,
    input  logic Data_in_C,
    output logic Data_out_Sum,
    output logic Data_out_Carry
);

    // Sum and carry of three one-bit inputs
    always_comb begin
        Data_out_Sum   = Data_in_A ^ Data_in_B ^ Data_in_C;
        Data_out_Carry = (Data_in_A & Data_in_B) | (Data_in_C & (Data_in_A ^ Data_in_B));
    end

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial adder/subtractor sequencer. Streams two WIDTH-bit operands LSB
// first through one full_adder cell over WIDTH cycles, then holds the result
// until the consumer acknowledges it.
// Subtraction is A + ~B + 1: B is inverted at capture and the carry flop is
// preloaded with 1.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds Data_out_Ovf (signed
// overflow) and the one flop that records the carry into the MSB cell.
module serial_addsub_seq
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Data_in_Start,
    input  logic             Data_in_Sub,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_Ack,
    output logic             Data_out_Busy,
    output logic             Data_out_Valid,
    output logic [WIDTH-1:0] Data_out_Sum,
    output logic             Data_out_Carry
`ifdef SERIAL_ADDSUB_OVF_EN
   ,output logic             Data_out_Ovf
`endif
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               fa_sum, fa_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               cin_msb_q, cin_msb_d;
`endif

    // The one shared adder cell sees the current LSBs and the running carry
    full_adder u_fa (
        .Data_in_A      (a_sr_q[0]),
        .Data_in_B      (b_sr_q[0]),
        .Data_in_C      (carry_q),
        .Data_out_Sum   (fa_sum),
        .Data_out_Carry (fa_carry)
    );

    // Next-state logic for the FSM, counter, shift registers and carry flop
    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        cin_msb_d = cin_msb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Data_in_Start) begin
                    a_sr_d   = Data_in_A;
                    b_sr_d   = (Data_in_Sub == OP_ADD) ? Data_in_B : ~Data_in_B;
                    carry_d  = (Data_in_Sub == OP_SUB);
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                if (cnt_q == LAST_BIT) begin
                    // Last bit is consumed on this edge; counter parks at zero
                    cnt_d   = '0;
                    state_d = ST_DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
                    cin_msb_d = carry_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Start is deliberately ignored here; only Ack releases the result
                if (Data_in_Ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shift registers are cleared on reset so an aborted operation leaves no residue.
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            cin_msb_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            cin_msb_q <= cin_msb_d;
`endif
        end
    end

    // Outputs decoded from state; the result is shown only while Valid
    always_comb begin
        Data_out_Busy  = (state_q == ST_SHIFT);
        Data_out_Valid = (state_q == ST_DONE);
        Data_out_Sum   = Data_out_Valid ? sum_sr_q : '0;
        Data_out_Carry = Data_out_Valid & carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        Data_out_Ovf   = Data_out_Valid & (cin_msb_q ^ carry_q);
`endif
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq: an 8-bit instance for directed
// vectors, handshake and reset cases, and a 4-bit instance swept over every
// operand pair and both operations. Ovf is checked when SERIAL_ADDSUB_OVF_EN
// is defined.
module tb_serial_addsub_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit instance signals
    logic       s8_start, s8_sub, s8_ack;
    logic [7:0] s8_a, s8_b;
    logic       busy8, valid8, carry8;
    logic [7:0] sum8;
    // 4-bit instance signals
    logic       s4_start, s4_sub, s4_ack;
    logic [3:0] s4_a, s4_b;
    logic       busy4, valid4, carry4;
    logic [3:0] sum4;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    serial_addsub_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .Data_in_Start(s8_start), .Data_in_Sub(s8_sub),
        .Data_in_A(s8_a), .Data_in_B(s8_b), .Data_in_Ack(s8_ack),
        .Data_out_Busy(busy8), .Data_out_Valid(valid8),
        .Data_out_Sum(sum8), .Data_out_Carry(carry8)
`ifdef SERIAL_ADDSUB_OVF_EN
       ,.Data_out_Ovf(ovf8)
`endif
    );

    serial_addsub_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .Data_in_Start(s4_start), .Data_in_Sub(s4_sub),
        .Data_in_A(s4_a), .Data_in_B(s4_b), .Data_in_Ack(s4_ack),
        .Data_out_Busy(busy4), .Data_out_Valid(valid4),
        .Data_out_Sum(sum4), .Data_out_Carry(carry4)
`ifdef SERIAL_ADDSUB_OVF_EN
       ,.Data_out_Ovf(ovf4)
`endif
    );

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 8-bit instance: compares on each rising Valid
    initial begin
        int   busy_cnt = 0;
        logic vprev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                vprev    = 1'b0;
            end else begin
                if (busy8) busy_cnt++;
                if (valid8 && !vprev) begin
                    check("w8_expected_pending", q8.size() != 0, 1);
                    if (q8.size() != 0) begin
                        e = q8.pop_front();
                        check("w8_sum", sum8, e.sum);
                        check("w8_carry", carry8, e.carry);
`ifdef SERIAL_ADDSUB_OVF_EN
                        check("w8_ovf", ovf8, e.ovf);
`endif
                        check("w8_busy_cycles", busy_cnt, 8);
                    end
                    busy_cnt = 0;
                end
                vprev = valid8;
            end
        end
    end

    // Monitor for the 4-bit instance
    initial begin
        int   busy_cnt = 0;
        logic vprev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                vprev    = 1'b0;
            end else begin
                if (busy4) busy_cnt++;
                if (valid4 && !vprev) begin
                    check("w4_expected_pending", q4.size() != 0, 1);
                    if (q4.size() != 0) begin
                        e = q4.pop_front();
                        check("w4_sum", sum4, e.sum);
                        check("w4_carry", carry4, e.carry);
`ifdef SERIAL_ADDSUB_OVF_EN
                        check("w4_ovf", ovf4, e.ovf);
`endif
                        check("w4_busy_cycles", busy_cnt, 4);
                    end
                    busy_cnt = 0;
                end
                vprev = valid4;
            end
        end
    end

    task automatic wait_valid8(input int budget);
        int n = 0;
        while (!valid8 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("w8_valid_within_budget", valid8, 1);
    endtask

    // Issue one op on the 8-bit instance, ack it, and confirm Valid drops
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum = es; e.carry = ec; e.ovf = eo;
        q8.push_back(e);
        s8_a = a; s8_b = b; s8_sub = sub; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        s8_a = ~a; s8_b = ~b; s8_sub = ~sub;
        wait_valid8(20);
        s8_ack = 1'b1;
        @(negedge clk);
        s8_ack = 1'b0;
        check("w8_valid_drop_after_ack", valid8, 0);
    endtask

    // Issue one op on the 4-bit instance with a bench-computed expectation
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        exp_t e;
        int   ai, bi, r, sa, sb, sr;
        int   n = 0;
        ai = int'(a); bi = int'(b);
        r  = sub ? (ai - bi) : (ai + bi);
        e.sum   = 8'((r + 16) % 16);
        e.carry = sub ? (ai >= bi) : (r > 15);
        sa = (ai >= 8) ? ai - 16 : ai;
        sb = (bi >= 8) ? bi - 16 : bi;
        sr = sub ? (sa - sb) : (sa + sb);
        e.ovf = (sr > 7) || (sr < -8);
        q4.push_back(e);
        s4_a = a; s4_b = b; s4_sub = sub; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        s4_a = ~a; s4_b = ~b;
        while (!valid4 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("w4_valid_within_budget", valid4, 1);
        s4_ack = 1'b1;
        @(negedge clk);
        s4_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s8_start = 0; s8_sub = 0; s8_ack = 0; s8_a = '0; s8_b = '0;
        s4_start = 0; s4_sub = 0; s4_ack = 0; s4_a = '0; s4_b = '0;
        #12;
        check("rst_busy", busy8, 0);
        check("rst_valid", valid8, 0);
        check("rst_sum", sum8, 0);
        check("rst_carry", carry8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ack while idle must not do anything
        s8_ack = 1'b1;
        @(negedge clk);
        s8_ack = 1'b0;
        check("idle_ack_valid", valid8, 0);
        check("idle_ack_busy", busy8, 0);

        // Directed arithmetic vectors
        op8(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1);
        op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        op8(8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Handshake: Start mid-SHIFT ignored, Valid held, Start+Ack drops Start
        begin
            exp_t e;
            e.sum = 8'h46; e.carry = 1'b0; e.ovf = 1'b0;
            q8.push_back(e);
            s8_a = 8'h12; s8_b = 8'h34; s8_sub = 1'b0; s8_start = 1'b1;
            @(negedge clk);
            s8_start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            s8_a = 8'hFF; s8_b = 8'hFF; s8_sub = 1'b1; s8_start = 1'b1;
            @(negedge clk);
            s8_start = 1'b0;
            wait_valid8(20);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("hold_valid", valid8, 1);
                check("hold_sum", sum8, 8'h46);
            end
            s8_start = 1'b1; s8_ack = 1'b1;
            @(negedge clk);
            s8_start = 1'b0; s8_ack = 1'b0;
            check("start_ack_valid", valid8, 0);
            check("start_ack_busy", busy8, 0);
            repeat (3) @(negedge clk);
            check("no_extra_op_busy", busy8, 0);
            check("no_extra_op_valid", valid8, 0);
        end

        // Reset mid-SHIFT aborts the op asynchronously
        s8_a = 8'h77; s8_b = 8'h22; s8_sub = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_valid", valid8, 0);
        check("abort_sum", sum8, 0);
        check("abort_carry", carry8, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep over both operations
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    op4(4'(a), 4'(b), s[0]);

        repeat (3) @(negedge clk);
        check("w8_queue_drained", q8.size(), 0);
        check("w4_queue_drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
- Bit-serial adder/subtractor sequencer that time-shares one full_adder cell over WIDTH cycles to add or subtract two WIDTH-bit operands, LSB first.
- Owns operand capture, shift registers, the carry flip-flop, the bit counter and the start/valid/ack handshake.
- Sits between a requesting controller and the single 1-bit adder resource in the arithmetic lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Data_in_Start  in  1  request; sampled only in IDLE
- Data_in_Sub  in  1  0 = A+B, 1 = A-B; captured with Start
- Data_in_A  in  WIDTH  operand A; captured with Start
- Data_in_B  in  WIDTH  operand B; captured with Start
- Data_in_Ack  in  1  consumer accepts result; meaningful only while Data_out_Valid=1
- Data_out_Busy  out  1  high in SHIFT
- Data_out_Valid  out  1  high in DONE
- Data_out_Sum  out  WIDTH  result; stable while Valid=1
- Data_out_Carry  out  1  final carry-out; for subtract, 1 = no borrow (A>=B unsigned)
- Data_out_Ovf  out  1  signed overflow (present only with SERIAL_ADDSUB_OVF_EN)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, carry FF=0, shift regs=0. Busy=0, Valid=0, Sum=0, Carry=0, Ovf=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: Start=1 at edge → latch A; latch B, or ~B if Sub=1; carry FF ← Sub; counter ← 0; go to SHIFT.
  - SHIFT: full_adder inputs are A_sr[0], B_sr[0], carry FF. Each cycle:
    - sum bit shifts into Sum_sr MSB end;
    - A_sr and B_sr shift right;
    - carry FF ← cell carry;
    - counter++.
  - SHIFT exit: when counter==WIDTH-1, the last bit is processed on that edge, then go to DONE.
  - DONE: Valid=1, Sum=Sum_sr, Carry=carry FF. Ack=1 → IDLE, Valid drops the next cycle.
- Latency: Start sampled at edge t; Busy high for exactly WIDTH cycles; Valid first high after edge t+WIDTH.
- Start is ignored in SHIFT and DONE: no re-latch, no queueing. Start and Ack together in DONE → Ack taken, Start dropped; requester must re-assert in IDLE.
- Ack outside DONE is ignored.
- Arithmetic is modulo 2^WIDTH; carry/borrow is reported only via Data_out_Carry.
- Counter width is $clog2(WIDTH); it never wraps past WIDTH-1.
- rst_n asserted mid-SHIFT or in DONE aborts immediately; no partial result is presented.
- Operand inputs may change freely after the Start edge.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN.
- Defined:
  - Data_out_Ovf exists.
  - In the final SHIFT cycle, register the carry-in to the MSB cell; Ovf = carry_in_msb XOR carry_out_msb.
  - Ovf is valid with Valid and cleared on reset.
- Undefined: no port, no extra flop.

Decomposition:
- Package serial_addsub_pkg:
  - state enum typedef (IDLE/SHIFT/DONE, 2-bit);
  - localparam OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: reuse the existing full_adder cell (Data_in_A/B/C → Data_out_Sum/Carry), instantiated once.
- Counter, shift registers and FSM stay in this module.

Test Plan:
- Add: WIDTH=8, A=8'h3C, B=8'h55, Sub=0, Start → Busy for 8 cycles; Valid with Sum=8'h91, Carry=0, Ovf=1.
- Subtract with borrow: A=8'h10, B=8'h20, Sub=1 → Sum=8'hF0, Carry=0, Ovf=0. Repeat with A=8'h20, B=8'h10 → Sum=8'h10, Carry=1.
- Wrap: A=8'hFF, B=8'h01, add → Sum=8'h00, Carry=1, Ovf=0. A=8'h80, B=8'h01, sub → Sum=8'h7F, Carry=1, Ovf=1.
- Handshake:
  - Start pulsed mid-SHIFT and again in DONE together with Ack → no extra op.
  - Valid held 5 cycles with no Ack; Sum stays stable.
  - After Ack, Valid=0 next cycle.
- Reset: assert rst_n=0 at cycle 4 of SHIFT → all outputs 0 asynchronously. New add 8'h01+8'h01 after release → Sum=8'h02 with no residue from the aborted op.
- Exhaustive: WIDTH=4, all 256 A/B pairs × both ops vs reference model; Busy exactly 4 cycles each.
